// File: rtl/drp_reconf_master.sv
// DRP reconfiguration master: holds the PLL in reset and applies a stream of
// (address, mask, data) read-modify-write entries over the DRP port. It then
// releases the PLL reset and waits for lock. DRDY and lock waits are bounded
// by timeouts that abort the sequence with a sticky ERR.
module drp_reconf_master #(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic        DCLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        ENT_VALID,
  input  logic [6:0]  ENT_ADDR,
  input  logic [15:0] ENT_MASK,
  input  logic [15:0] ENT_DATA,
  input  logic        ENT_LAST,
  output logic        ENT_READY,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        PLL_RST,
  input  logic        LOCKED,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  // One counter serves both waits, so it is sized for the larger limit.
  localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRDY_LIMIT = CNT_W'(DRDY_TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ASSERT,
    S_FETCH,
    S_READ,
    S_WAIT_R,
    S_WRITE,
    S_WAIT_W,
    S_RELEASE,
    S_WAIT_LOCK,
    S_FIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;     // cycles since the DEN cycle / since PLL_RST fell
  logic [15:0]      mask_q;
  logic [15:0]      data_q;
  logic             last_q;

  // Sequencer FSM with every output registered.
  always_ff @(posedge DCLK) begin
    // NOTE: state and outputs use non-blocking assignments so every branch
    // reads the pre-edge values; the reset is synchronous, so it sits inside
    // the clocked block rather than in the sensitivity list.
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      ENT_READY <= 1'b0;
      DADDR     <= '0;
      DEN       <= 1'b0;
      DWE       <= 1'b0;
      DI        <= '0;
      PLL_RST   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      // NOTE: strobes default low here and are raised only on the edge that
      // enters their one-cycle state, which keeps them single-cycle pulses.
      DEN  <= 1'b0;
      DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START) begin
            ERR   <= 1'b0;
            BUSY  <= 1'b1;
            state <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          PLL_RST   <= 1'b1;
          ENT_READY <= 1'b1;
          state     <= S_FETCH;
        end
        S_FETCH: begin
          if (ENT_VALID) begin
            ENT_READY <= 1'b0;
            mask_q    <= ENT_MASK;
            data_q    <= ENT_DATA;
            last_q    <= ENT_LAST;
            DADDR     <= ENT_ADDR;
            DWE       <= 1'b0;
            DEN       <= 1'b1;
            state     <= S_READ;
          end
        end
        S_READ: begin
          // The DEN cycle is cycle 0; DRDY is first eligible in the next one.
          cnt   <= CNT_ONE;
          state <= S_WAIT_R;
        end
        S_WAIT_R: begin
          if (DRDY) begin
            // Masked bits keep the value just read; the rest take new data.
            DI    <= (DO & mask_q) | (data_q & ~mask_q);
            DWE   <= 1'b1;
            DEN   <= 1'b1;
            state <= S_WRITE;
          end else if (cnt == DRDY_LIMIT) begin
            ERR     <= 1'b1;
            PLL_RST <= 1'b0;
            BUSY    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_WRITE: begin
          cnt   <= CNT_ONE;
          state <= S_WAIT_W;
        end
        S_WAIT_W: begin
          if (DRDY) begin
            if (last_q) begin
              PLL_RST <= 1'b0;
              state   <= S_RELEASE;
            end else begin
              ENT_READY <= 1'b1;
              state     <= S_FETCH;
            end
          end else if (cnt == DRDY_LIMIT) begin
            ERR     <= 1'b1;
            PLL_RST <= 1'b0;
            BUSY    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_RELEASE: begin
          // PLL_RST fell on entry to this state; count lock cycles from here.
          cnt   <= CNT_ONE;
          state <= S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (LOCKED) begin
            DONE  <= 1'b1;
            state <= S_FIN;
          end else if (cnt == LOCK_LIMIT) begin
            ERR   <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_FIN: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drp_reconf_master.sv
// Self-checking bench for drp_reconf_master. A behavioural PLL/DRP responder
// keeps a 128-entry register file and answers DEN with configurable DRDY
// latency. A reference model derives the expected DRP transfer log for each
// entry list from the read-modify-write rule.
module tb_drp_reconf_master;

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } entry_t;

  logic        DCLK, RST_N, START;
  logic        ENT_VALID, ENT_LAST, ENT_READY;
  logic [6:0]  ENT_ADDR, DADDR;
  logic [15:0] ENT_MASK, ENT_DATA, DI, DO;
  logic        DEN, DWE, DRDY, PLL_RST, LOCKED, BUSY, DONE, ERR;

  int checks = 0;
  int errors = 0;

  // Responder / PLL model state
  logic [15:0] regs [128];
  logic [15:0] pend_do;
  int          drdy_lat    = 1;
  int          silent_addr = -1;
  int          lock_delay  = 0;
  int          pend        = 0;
  int          lock_cnt    = -1;
  int          done_cnt    = 0;
  int          pll_falls   = 0;
  bit          inject_drdy = 0;
  bit          outst       = 0;
  bit          ready_viol  = 0;
  bit          overlap_viol = 0;
  bit          pll_viol    = 0;
  bit          prev_pll    = 0;

  entry_t      ents[$];
  logic [23:0] xfer_q[$];   // {we, addr, write data (0 for reads)}
  logic [23:0] exp_q[$];

  drp_reconf_master #(.DRDY_TIMEOUT(64), .LOCK_TIMEOUT(1024)) dut (
    .DCLK(DCLK), .RST_N(RST_N), .START(START),
    .ENT_VALID(ENT_VALID), .ENT_ADDR(ENT_ADDR), .ENT_MASK(ENT_MASK),
    .ENT_DATA(ENT_DATA), .ENT_LAST(ENT_LAST), .ENT_READY(ENT_READY),
    .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
    .PLL_RST(PLL_RST), .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial begin
    DCLK = 1'b0;
    forever #5 DCLK = ~DCLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  // DRP responder, PLL lock model and passive monitors (all on the falling edge)
  initial begin
    DRDY   = 1'b0;
    DO     = 16'h0;
    LOCKED = 1'b0;
    forever begin
      @(negedge DCLK);
      DRDY = 1'b0;
      DO   = 16'($urandom);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          DRDY  = 1'b1;
          DO    = pend_do;
          outst = 1'b0;
        end
      end
      if (inject_drdy) begin
        DRDY        = 1'b1;
        inject_drdy = 1'b0;
      end
      if (DEN === 1'b1) begin
        if (outst) overlap_viol = 1'b1;
        if (PLL_RST !== 1'b1) pll_viol = 1'b1;
        xfer_q.push_back({DWE, DADDR, DWE ? DI : 16'h0});
        outst = 1'b1;
        if (DWE) begin
          regs[DADDR] = DI;
          pend = drdy_lat;
        end else begin
          pend_do = regs[DADDR];
          pend = (int'(DADDR) == silent_addr) ? 0 : drdy_lat;
        end
      end
      if (outst && ENT_READY === 1'b1) ready_viol = 1'b1;
      if (DONE === 1'b1) done_cnt++;
      if (PLL_RST === 1'b1) begin
        LOCKED   = 1'b0;
        lock_cnt = -1;
      end else if (prev_pll) begin
        lock_cnt = lock_delay;
        pll_falls++;
      end
      if (lock_cnt == 0) LOCKED = 1'b1;
      if (lock_cnt > 0) lock_cnt--;
      prev_pll = (PLL_RST === 1'b1);
    end
  end

  task automatic clear_mon();
    xfer_q.delete();
    done_cnt     = 0;
    pll_falls    = 0;
    ready_viol   = 1'b0;
    overlap_viol = 1'b0;
    pll_viol     = 1'b0;
  endtask

  // Reference model: each entry is a read then a write of (old & mask) | (data & ~mask).
  task automatic build_exp();
    logic [15:0] m [128];
    logic [15:0] nv;
    m = regs;
    exp_q.delete();
    foreach (ents[i]) begin
      exp_q.push_back({1'b0, ents[i].addr, 16'h0000});
      nv = (m[ents[i].addr] & ents[i].mask) | (ents[i].data & ~ents[i].mask);
      m[ents[i].addr] = nv;
      exp_q.push_back({1'b1, ents[i].addr, nv});
    end
  endtask

  task automatic random_entries(input int n);
    ents.delete();
    for (int i = 0; i < n; i++)
      ents.push_back(entry_t'{7'($urandom), 16'($urandom), 16'($urandom)});
  endtask

  // Pulses START, feeds the entry list (optionally with a stray DRDY and a
  // START pulse during entry start_at), then waits for BUSY to drop.
  task automatic run_seq(input bit stray, input int start_at, output int waited);
    int k;
    @(negedge DCLK); START = 1'b1;
    @(negedge DCLK); START = 1'b0;
    if (stray) begin
      @(negedge DCLK); inject_drdy = 1'b1;
      repeat (3) @(negedge DCLK);
    end
    foreach (ents[i]) begin
      repeat ($urandom_range(0, 1)) @(negedge DCLK);
      ENT_VALID = 1'b1;
      ENT_ADDR  = ents[i].addr;
      ENT_MASK  = ents[i].mask;
      ENT_DATA  = ents[i].data;
      ENT_LAST  = (i == ents.size() - 1);
      if (i == start_at) START = 1'b1;
      k = 0;
      while (ENT_READY !== 1'b1 && k < 400) begin @(negedge DCLK); k++; end
      @(negedge DCLK);
      ENT_VALID = 1'b0;
      START     = 1'b0;
    end
    k = 0;
    while (BUSY !== 1'b0 && k < 3000) begin @(negedge DCLK); k++; end
    waited = k;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge DCLK);
      checks++;
      if ({DADDR, DEN, DWE, DI, PLL_RST, ENT_READY, BUSY, DONE, ERR} !== 30'h0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", i,
                 {DADDR, DEN, DWE, DI, PLL_RST, ENT_READY, BUSY, DONE, ERR});
      end
    end
    START = 1'b0;
    RST_N = 1'b1;
    repeat (6) @(negedge DCLK);
    checks++;
    if (xfer_q.size() != 0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: den_count=%0d busy=%b want 0/0", xfer_q.size(), BUSY);
    end
  endtask

  // Cycle-by-cycle profile of a one-entry sequence with zero-wait DRDY and
  // immediate lock: n counts cycles after the edge that samples START.
  task automatic test_latency();
    logic [5:0] exp_v, got_v;
    drdy_lat   = 1;
    lock_delay = 0;
    random_entries(1);
    build_exp();
    clear_mon();
    @(negedge DCLK);
    ENT_VALID = 1'b1;
    ENT_ADDR  = ents[0].addr;
    ENT_MASK  = ents[0].mask;
    ENT_DATA  = ents[0].data;
    ENT_LAST  = 1'b1;
    START     = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge DCLK);
      START = 1'b0;
      if (n == 3) ENT_VALID = 1'b0;
      exp_v = {n <= 9, n >= 2 && n <= 6, n == 2, n == 3 || n == 5, n == 5, n == 9};
      got_v = {BUSY, PLL_RST, ENT_READY, DEN, DEN & DWE, DONE};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL latency cycle %0d {busy,pll_rst,ready,den,wr,done}: got %b want %b",
                 n, got_v, exp_v);
      end
    end
    checks++;
    if (xfer_q.size() != 2 || xfer_q[0] !== exp_q[0] || xfer_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL latency_xfers: got %0d transfers, want %h %h", xfer_q.size(), exp_q[0], exp_q[1]);
    end
  endtask

  task automatic test_single_rmw();
    int w;
    ents.delete();
    ents.push_back(entry_t'{7'h08, 16'h1000, 16'h0041});
    regs[8]    = 16'hF3C5;
    drdy_lat   = 1;
    lock_delay = 10;
    clear_mon();
    run_seq(1'b0, -1, w);
    exp_q.delete();
    exp_q.push_back({1'b0, 7'h08, 16'h0000});
    exp_q.push_back({1'b1, 7'h08, 16'h1041});
    checks++;
    if (xfer_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rmw_count: got %0d want %0d", xfer_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < xfer_q.size()) begin
      checks++;
      if (xfer_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rmw_xfer[%0d]: got %h want %h", i, xfer_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || ERR !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rmw_status: done=%0d err=%b busy=%b want 1/0/0", done_cnt, ERR, BUSY);
    end
  endtask

  task automatic test_three_batch();
    int w;
    ents.delete();
    ents.push_back(entry_t'{7'h08, 16'h0000, 16'h1111});
    ents.push_back(entry_t'{7'h09, 16'h0000, 16'h2222});
    ents.push_back(entry_t'{7'h16, 16'h0000, 16'h3333});
    drdy_lat   = 4;
    lock_delay = 5;
    clear_mon();
    run_seq(1'b0, -1, w);
    checks++;
    if (xfer_q.size() != 6) begin
      errors++;
      $display("FAIL batch_den_count: got %0d want 6", xfer_q.size());
    end
    checks++;
    if (xfer_q.size() == 6 && (xfer_q[1] !== {1'b1, 7'h08, 16'h1111} ||
        xfer_q[3] !== {1'b1, 7'h09, 16'h2222} || xfer_q[5] !== {1'b1, 7'h16, 16'h3333})) begin
      errors++;
      $display("FAIL batch_writes: got %h %h %h want 1081111 1092222 1163333",
               xfer_q[1], xfer_q[3], xfer_q[5]);
    end
    checks++;
    if (pll_falls != 1 || pll_viol || ready_viol || overlap_viol) begin
      errors++;
      $display("FAIL batch_protocol: pll_falls=%0d pll_viol=%b ready_viol=%b overlap=%b want 1/0/0/0",
               pll_falls, pll_viol, ready_viol, overlap_viol);
    end
    checks++;
    if (done_cnt != 1 || ERR !== 1'b0) begin
      errors++;
      $display("FAIL batch_status: done=%0d err=%b want 1/0", done_cnt, ERR);
    end
  endtask

  task automatic test_random();
    int w;
    for (int s = 0; s < 6; s++) begin
      random_entries($urandom_range(1, 4));
      drdy_lat   = $urandom_range(1, 5);
      lock_delay = $urandom_range(0, 15);
      build_exp();
      clear_mon();
      run_seq(1'b0, -1, w);
      checks++;
      if (xfer_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL random%0d_count: got %0d want %0d", s, xfer_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < xfer_q.size()) begin
        checks++;
        if (xfer_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random%0d_xfer[%0d]: got %h want %h", s, i, xfer_q[i], exp_q[i]);
        end
      end
      checks++;
      if (done_cnt != 1 || ERR !== 1'b0 || BUSY !== 1'b0 || ready_viol || overlap_viol || pll_viol) begin
        errors++;
        $display("FAIL random%0d_status: done=%0d err=%b busy=%b viol=%b%b%b want 1/0/0/000",
                 s, done_cnt, ERR, BUSY, ready_viol, overlap_viol, pll_viol);
      end
    end
  endtask

  task automatic test_robust();
    int w, k, sz;
    // Stray DRDY in FETCH plus a START pulse while busy.
    random_entries(2);
    drdy_lat   = 2;
    lock_delay = 3;
    build_exp();
    clear_mon();
    run_seq(1'b1, 1, w);
    repeat (5) @(negedge DCLK);
    checks++;
    if (xfer_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL robust_count: got %0d want %0d", xfer_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < xfer_q.size()) begin
      checks++;
      if (xfer_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL robust_xfer[%0d]: got %h want %h", i, xfer_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || ERR !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL robust_status: done=%0d err=%b busy=%b want 1/0/0", done_cnt, ERR, BUSY);
    end
    // Reset pulled during WAIT_W.
    random_entries(1);
    drdy_lat = 4;
    clear_mon();
    @(negedge DCLK); START = 1'b1;
    @(negedge DCLK); START = 1'b0;
    ENT_VALID = 1'b1;
    ENT_ADDR  = ents[0].addr;
    ENT_MASK  = ents[0].mask;
    ENT_DATA  = ents[0].data;
    ENT_LAST  = 1'b1;
    k = 0;
    while (!(DEN === 1'b1 && DWE === 1'b1) && k < 100) begin @(negedge DCLK); k++; end
    ENT_VALID = 1'b0;
    checks++;
    if (k >= 100) begin
      errors++;
      $display("FAIL midreset_write: got no write DEN within %0d cycles, want one", k);
    end
    @(negedge DCLK); RST_N = 1'b0;
    @(negedge DCLK);
    checks++;
    if ({DADDR, DEN, DWE, DI, PLL_RST, ENT_READY, BUSY, DONE, ERR} !== 30'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want 0",
               {DADDR, DEN, DWE, DI, PLL_RST, ENT_READY, BUSY, DONE, ERR});
    end
    RST_N = 1'b1;
    sz = xfer_q.size();
    repeat (12) @(negedge DCLK);
    checks++;
    if (xfer_q.size() != sz || BUSY !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL midreset_quiet: new_dens=%0d busy=%b done=%0d want 0/0/0",
               xfer_q.size() - sz, BUSY, done_cnt);
    end
  endtask

  task automatic test_drdy_timeout();
    int k, n;
    ents.delete();
    ents.push_back(entry_t'{7'h4E, 16'($urandom), 16'($urandom)});
    silent_addr = 'h4E;
    drdy_lat    = 1;
    clear_mon();
    @(negedge DCLK); START = 1'b1;
    @(negedge DCLK); START = 1'b0;
    ENT_VALID = 1'b1;
    ENT_ADDR  = ents[0].addr;
    ENT_MASK  = ents[0].mask;
    ENT_DATA  = ents[0].data;
    ENT_LAST  = 1'b1;
    k = 0;
    while (DEN !== 1'b1 && k < 100) begin @(negedge DCLK); k++; end
    ENT_VALID = 1'b0;
    checks++;
    if (DEN !== 1'b1) begin
      errors++;
      $display("FAIL drdy_to_read: got den=%b want 1", DEN);
    end
    n = 0;
    while (ERR !== 1'b1 && n < 200) begin @(negedge DCLK); n++; end
    checks++;
    if (n < 64 || n > 65) begin
      errors++;
      $display("FAIL drdy_to_time: err after %0d cycles, want 64..65", n);
    end
    checks++;
    if (xfer_q.size() != 1 || PLL_RST !== 1'b0 || BUSY !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL drdy_to_state: dens=%0d pll_rst=%b busy=%b done=%0d want 1/0/0/0",
               xfer_q.size(), PLL_RST, BUSY, done_cnt);
    end
    silent_addr = -1;
    repeat (2) @(negedge DCLK);
    outst = 1'b0;
  endtask

  task automatic test_lock_timeout();
    int k, n, w;
    random_entries(1);
    drdy_lat   = 1;
    lock_delay = -1;
    clear_mon();
    @(negedge DCLK); START = 1'b1;
    @(negedge DCLK); START = 1'b0;
    ENT_VALID = 1'b1;
    ENT_ADDR  = ents[0].addr;
    ENT_MASK  = ents[0].mask;
    ENT_DATA  = ents[0].data;
    ENT_LAST  = 1'b1;
    k = 0;
    while (DEN !== 1'b1 && k < 100) begin @(negedge DCLK); k++; end
    ENT_VALID = 1'b0;
    while (PLL_RST !== 1'b0 && k < 200) begin @(negedge DCLK); k++; end
    n = 0;
    while (ERR !== 1'b1 && n < 1100) begin @(negedge DCLK); n++; end
    checks++;
    if (n < 1024 || n > 1025) begin
      errors++;
      $display("FAIL lock_to_time: err %0d cycles after PLL_RST fell, want 1024..1025", n);
    end
    checks++;
    if (ERR !== 1'b1 || BUSY !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL lock_to_state: err=%b busy=%b done=%0d want 1/0/0", ERR, BUSY, done_cnt);
    end
    // Restart clears ERR and completes.
    random_entries(2);
    lock_delay = 3;
    build_exp();
    clear_mon();
    run_seq(1'b0, -1, w);
    checks++;
    if (ERR !== 1'b0 || done_cnt != 1 || xfer_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL restart: err=%b done=%0d xfers=%0d want 0/1/%0d",
               ERR, done_cnt, xfer_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < xfer_q.size()) begin
      checks++;
      if (xfer_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL restart_xfer[%0d]: got %h want %h", i, xfer_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    RST_N     = 1'b0;
    START     = 1'b0;
    ENT_VALID = 1'b0;
    ENT_ADDR  = '0;
    ENT_MASK  = '0;
    ENT_DATA  = '0;
    ENT_LAST  = 1'b0;
    for (int i = 0; i < 128; i++) regs[i] = 16'($urandom);
    test_reset();
    test_latency();
    test_single_rmw();
    test_three_batch();
    test_random();
    test_robust();
    test_drdy_timeout();
    test_lock_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
